// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline control slice: FSM state encodings,
// memory-wait timing defaults and register-file geometry.
package arm_pipe_pkg;

    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int WAIT_W          = 8;
    localparam int REG_W           = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Purely combinational read-after-write hazard compare between the ID stage
// sources and the destinations of the instructions in EXE and MEM.
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hazard
);

    logic [1:0][REG_W-1:0] src;
    logic [1:0]            src_used;
    logic [1:0]            src_hit;

    assign src      = {id_src2, id_src1};
    assign src_used = {id_two_src, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic exe_hit;
            logic mem_hit;

            assign exe_hit = exe_wb_en && (src[gi] == exe_dest);
            assign mem_hit = mem_wb_en && (src[gi] == mem_dest);

            // With forwarding only a load in EXE cannot be bypassed in time.
            assign src_hit[gi] = src_used[gi] &&
                                 (fwd_en ? (exe_hit && exe_mem_read)
                                         : (exe_hit || mem_hit));
        end
    endgenerate

    assign hazard = id_valid && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / SRAM-wait controller: produces freeze and flush strobes,
// tracks SRAM wait time with a timeout into a sticky error state, and keeps
// saturating performance counters for stalls and branch flushes.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             if_freeze,
    output logic             id_freeze,
    output logic             if2id_flush,
    output logic             id2exe_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Last wait count that may still be spent in MEM_WAIT before giving up.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_e       state_reg;
    pipe_state_e       state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;
    logic              hazard;
    logic              run_stall;
    logic              run_flush;

    hazard_detect u_hazard_detect (
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_req && !sram_ready) begin
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (sram_ready) begin
                    state_next = ST_RUN;
                end else if (wait_cnt_reg >= WAIT_LAST) begin
                    state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Branch flush outranks a hazard stall: the stalled instruction is squashed anyway.
    always_comb begin
        if_freeze    = 1'b0;
        id_freeze    = 1'b0;
        if2id_flush  = 1'b0;
        id2exe_flush = 1'b0;
        pipe_freeze  = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_RUN: begin
                    if (branch_taken) begin
                        if2id_flush  = 1'b1;
                        id2exe_flush = 1'b1;
                    end else if (hazard) begin
                        if_freeze    = 1'b1;
                        id_freeze    = 1'b1;
                        id2exe_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT, ST_ERROR: begin
                    if_freeze   = 1'b1;
                    id_freeze   = 1'b1;
                    pipe_freeze = 1'b1;
                end
                default: begin
                    if_freeze = 1'b0;
                end
            endcase
        end
    end

    assign run_stall = (state_reg == ST_RUN) && !branch_taken && hazard;
    assign run_flush = (state_reg == ST_RUN) && branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_RUN && state_next == ST_MEM_WAIT) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_MEM_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (run_stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (run_flush && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign mem_err      = (state_reg == ST_ERROR);
    assign state        = state_reg;
    assign stall_cycles = stall_cnt_reg;
    assign flush_events = flush_cnt_reg;

endmodule
